// File: rtl/i2c_sht_target.sv
// I2C target modelling an SHT40-style sensor: ACKs command writes at TARGET_ADDR and
// returns a T/RH measurement frame with CRC-8 on reads. Open-drain SDA, SCL input only.
module i2c_sht_target #(
  parameter logic [6:0] TARGET_ADDR = 7'h44,
  parameter int         READ_BYTES  = 6,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Scl_Data,
  inout  wire         Sda_Data,
  input  logic [15:0] Meas_Temp,
  input  logic [15:0] Meas_Hum,
  output logic        Cmd_Valid,
  output logic [7:0]  Cmd_Byte,
  output logic        Read_Done,
  output logic [2:0]  Target_State_Out
);

  typedef enum logic [2:0] {
    IDLE = 3'd0, ADDR = 3'd1, ADDR_ACK = 3'd2, WRITE = 3'd3,
    WRITE_ACK = 3'd4, READ = 3'd5, READ_ACK = 3'd6
  } state_t;

  function automatic logic [7:0] crc8(input logic [15:0] w);
    logic [7:0] c;
    c = 8'hFF;
    for (int i = 15; i >= 0; i--) begin
      if (c[7] ^ w[i]) c = {c[6:0], 1'b0} ^ 8'h31;
      else             c = {c[6:0], 1'b0};
    end
    return c;
  endfunction

  function automatic logic [7:0] frame_byte(input logic [2:0] idx, input logic [15:0] t,
                                            input logic [15:0] h, input logic [7:0] ct,
                                            input logic [7:0] ch);
    logic [7:0] b;
    case (idx)
      3'd0:    b = t[15:8];
      3'd1:    b = t[7:0];
      3'd2:    b = ct;
      3'd3:    b = h[15:8];
      3'd4:    b = h[7:0];
      3'd5:    b = ch;
      default: b = 8'hFF;
    endcase
    if (int'(idx) >= READ_BYTES) b = 8'hFF;
    return b;
  endfunction

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic scl_hist_q, scl_hist_d, sda_hist_q, sda_hist_d;

  state_t      state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        rw_q, rw_d;
  logic [2:0]  byte_idx_q, byte_idx_d;
  logic [7:0]  tx_q, tx_d;
  logic [15:0] snap_t_q, snap_t_d, snap_h_q, snap_h_d;
  logic [7:0]  cmd_byte_q, cmd_byte_d;
  logic        cmd_valid_q, cmd_valid_d, read_done_q, read_done_d;
  logic        sda_oe_q, sda_oe_d;

  logic scl_s, sda_s, scl_rise, scl_fall, start_ev, stop_ev;
  logic [7:0] crc_t, crc_h, frame0, frame_nxt;
  logic [2:0] idx_inc;

  // Bus idles high, so the synchronisers reset to 1 to avoid phantom edges.
  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], Scl_Data};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], Sda_Data};
    scl_hist_d = scl_sync_q[SYNC_STAGES-1];
    sda_hist_d = sda_sync_q[SYNC_STAGES-1];
  end

  assign scl_s    = scl_sync_q[SYNC_STAGES-1];
  assign sda_s    = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_hist_q;
  assign scl_fall = ~scl_s & scl_hist_q;
  // SCL high in both samples excludes SDA edges coincident with an SCL edge.
  assign start_ev = scl_s & scl_hist_q & sda_hist_q & ~sda_s;
  assign stop_ev  = scl_s & scl_hist_q & ~sda_hist_q & sda_s;

  assign crc_t     = crc8(snap_t_q);
  assign crc_h     = crc8(snap_h_q);
  assign idx_inc   = (byte_idx_q == 3'd7) ? 3'd7 : byte_idx_q + 3'd1;
  assign frame0    = frame_byte(3'd0, snap_t_q, snap_h_q, crc_t, crc_h);
  assign frame_nxt = frame_byte(idx_inc, snap_t_q, snap_h_q, crc_t, crc_h);

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    rw_d        = rw_q;
    byte_idx_d  = byte_idx_q;
    tx_d        = tx_q;
    snap_t_d    = snap_t_q;
    snap_h_d    = snap_h_q;
    cmd_byte_d  = cmd_byte_q;
    cmd_valid_d = 1'b0;
    read_done_d = 1'b0;
    sda_oe_d    = sda_oe_q;
    if (start_ev) begin
      state_d   = ADDR;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
    end else if (stop_ev) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: sda_oe_d = 1'b0;
        ADDR, WRITE: begin
          if (scl_rise) begin
            shreg_d   = {shreg_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            if (state_q == WRITE) begin
              sda_oe_d    = 1'b1;
              cmd_byte_d  = shreg_q;
              cmd_valid_d = 1'b1;
              state_d     = WRITE_ACK;
            end else if (shreg_q[7:1] == TARGET_ADDR) begin
              sda_oe_d = 1'b1;
              rw_d     = shreg_q[0];
              state_d  = ADDR_ACK;
              if (shreg_q[0]) begin
                snap_t_d = Meas_Temp;
                snap_h_d = Meas_Hum;
              end
            end else begin
              state_d = IDLE;
            end
          end
        end
        ADDR_ACK: if (scl_fall) begin
          bit_cnt_d = 4'd0;
          if (rw_q) begin
            byte_idx_d = 3'd0;
            tx_d       = frame0;
            sda_oe_d   = ~frame0[7];
            state_d    = READ;
          end else begin
            sda_oe_d = 1'b0;
            state_d  = WRITE;
          end
        end
        WRITE_ACK: if (scl_fall) begin
          sda_oe_d  = 1'b0;
          bit_cnt_d = 4'd0;
          state_d   = WRITE;
        end
        READ: if (scl_fall) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            sda_oe_d = 1'b0;
            state_d  = READ_ACK;
          end else begin
            tx_d     = {tx_q[6:0], 1'b0};
            sda_oe_d = ~tx_q[6];
          end
        end
        READ_ACK: begin
          if (scl_rise) begin
            if (!sda_s) begin
              byte_idx_d = idx_inc;
              tx_d       = frame_nxt;
            end else begin
              read_done_d = 1'b1;
              state_d     = IDLE;
            end
          end else if (scl_fall) begin
            bit_cnt_d = 4'd0;
            sda_oe_d  = ~tx_q[7];
            state_d   = READ;
          end
        end
        default: begin
          state_d  = IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q  <= '1;
      sda_sync_q  <= '1;
      scl_hist_q  <= 1'b1;
      sda_hist_q  <= 1'b1;
      state_q     <= IDLE;
      bit_cnt_q   <= 4'd0;
      shreg_q     <= 8'd0;
      rw_q        <= 1'b0;
      byte_idx_q  <= 3'd0;
      tx_q        <= 8'd0;
      snap_t_q    <= 16'd0;
      snap_h_q    <= 16'd0;
      cmd_byte_q  <= 8'd0;
      cmd_valid_q <= 1'b0;
      read_done_q <= 1'b0;
      sda_oe_q    <= 1'b0;
    end else begin
      scl_sync_q  <= scl_sync_d;
      sda_sync_q  <= sda_sync_d;
      scl_hist_q  <= scl_hist_d;
      sda_hist_q  <= sda_hist_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      rw_q        <= rw_d;
      byte_idx_q  <= byte_idx_d;
      tx_q        <= tx_d;
      snap_t_q    <= snap_t_d;
      snap_h_q    <= snap_h_d;
      cmd_byte_q  <= cmd_byte_d;
      cmd_valid_q <= cmd_valid_d;
      read_done_q <= read_done_d;
      sda_oe_q    <= sda_oe_d;
    end
  end

  assign Sda_Data         = sda_oe_q ? 1'b0 : 1'bz;
  assign Cmd_Valid        = cmd_valid_q;
  assign Cmd_Byte         = cmd_byte_q;
  assign Read_Done        = read_done_q;
  assign Target_State_Out = state_q;

endmodule

// File: tb/tb_i2c_sht_target.sv
// Bench for i2c_sht_target: bit-banged I2C master with a frame/CRC reference model.
module tb_i2c_sht_target;
  localparam int Q = 8;  // clk per quarter SCL period

  logic        clk = 1'b0, rst_n = 1'b0, scl = 1'b1, m_sda_low = 1'b0;
  logic [15:0] temp = 16'hBEEF, hum = 16'hBEEF;
  wire         sda_bus;
  logic        cmd_valid, read_done;
  logic [7:0]  cmd_byte;
  logic [2:0]  st;
  int total = 0, bad = 0;
  int cv_cnt = 0, rd_cnt = 0, low_cnt = 0;

  pullup (sda_bus);
  assign sda_bus = m_sda_low ? 1'b0 : 1'bz;
  always #5 clk = ~clk;

  i2c_sht_target dut (
    .clk(clk), .rst_n(rst_n), .Scl_Data(scl), .Sda_Data(sda_bus),
    .Meas_Temp(temp), .Meas_Hum(hum), .Cmd_Valid(cmd_valid), .Cmd_Byte(cmd_byte),
    .Read_Done(read_done), .Target_State_Out(st)
  );

  // Pulse widths fold into these counts: a 1-clk pulse adds exactly one.
  always @(posedge clk) begin
    if (cmd_valid) cv_cnt++;
    if (read_done) rd_cnt++;
    if (!m_sda_low && sda_bus === 1'b0) low_cnt++;
  end

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: byte-wise CRC-8 and frame table
  function automatic logic [7:0] m_crc(input logic [15:0] w);
    logic [7:0] c;
    c = 8'hFF;
    for (int k = 0; k < 2; k++) begin
      c = c ^ ((k == 0) ? w[15:8] : w[7:0]);
      for (int j = 0; j < 8; j++) c = c[7] ? ((c << 1) ^ 8'h31) : (c << 1);
    end
    return c;
  endfunction

  function automatic logic [7:0] m_frame(input int idx, input logic [15:0] t, input logic [15:0] h);
    case (idx)
      0: return t[15:8];
      1: return t[7:0];
      2: return m_crc(t);
      3: return h[15:8];
      4: return h[7:0];
      5: return m_crc(h);
      default: return 8'hFF;
    endcase
  endfunction

  task automatic waitq();
    repeat (Q) @(negedge clk);
  endtask

  task automatic clk_bit(input logic b, output logic seen);
    waitq(); m_sda_low = ~b;
    waitq(); scl = 1'b1;
    waitq(); seen = sda_bus;
    waitq(); scl = 1'b0;
  endtask

  task automatic i2c_start();
    waitq(); m_sda_low = 1'b0;
    waitq(); scl = 1'b1;
    waitq(); m_sda_low = 1'b1;
    waitq(); scl = 1'b0;
  endtask

  task automatic i2c_stop();
    waitq(); m_sda_low = 1'b1;
    waitq(); scl = 1'b1;
    waitq(); m_sda_low = 1'b0;
    waitq(); waitq();
  endtask

  task automatic wr_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
    clk_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic rd_byte(input logic ack_it, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, s);
      b[i] = s;
    end
    clk_bit(~ack_it, s);
  endtask

  task automatic rd_xfer(input int n, input logic nack_last, input logic [15:0] t,
                         input logic [15:0] h, input string tag);
    logic [7:0] b;
    for (int k = 0; k < n; k++) begin
      rd_byte(!(nack_last && k == n - 1), b);
      chk($sformatf("%s_b%0d", tag, k), b, m_frame(k > 7 ? 7 : k, t, h));
    end
  endtask

  initial begin
    logic a;
    logic [7:0] rb, wb;
    logic [7:0] exp3 [6];
    logic [15:0] t, h;
    logic [6:0] ad;
    int c0, r0, l0, n;
    exp3 = '{8'hBE, 8'hEF, 8'h92, 8'hBE, 8'hEF, 8'h92};

    repeat (4) @(negedge clk);
    chk("rst_state", st, 0);
    chk("rst_cv", cmd_valid, 0);
    chk("rst_cmd", cmd_byte, 0);
    chk("rst_rd", read_done, 0);
    chk("rst_sda", sda_bus, 1);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // 1: write command
    c0 = cv_cnt;
    i2c_start();
    wr_byte(8'h88, a); chk("t1_addr_ack", a, 1);
    wr_byte(8'hFD, a); chk("t1_data_ack", a, 1);
    i2c_stop();
    chk("t1_cv", cv_cnt - c0, 1);
    chk("t1_cmd", cmd_byte, 8'hFD);
    chk("t1_idle", st, 0);

    // 2: wrong address
    c0 = cv_cnt; l0 = low_cnt;
    i2c_start();
    wr_byte(8'h8A, a); chk("t2_addr_nack", a, 0);
    chk("t2_idle", st, 0);
    wr_byte(8'($urandom), a); chk("t2_data_nack", a, 0);
    i2c_stop();
    chk("t2_low", low_cnt - l0, 0);
    chk("t2_cv", cv_cnt - c0, 0);

    // 3: command, repeated start, 6-byte read of 0xBEEF
    temp = 16'hBEEF; hum = 16'hBEEF;
    i2c_start();
    wr_byte(8'h88, a); chk("t3_waddr", a, 1);
    wr_byte(8'hFD, a); chk("t3_cmd", a, 1);
    i2c_start();
    wr_byte(8'h89, a); chk("t3_raddr", a, 1);
    r0 = rd_cnt;
    for (int k = 0; k < 6; k++) begin
      rd_byte(k != 5, rb);
      chk($sformatf("t3_b%0d", k), rb, exp3[k]);
    end
    chk("t3_rd", rd_cnt - r0, 1);
    chk("t3_idle", st, 0);
    i2c_stop();

    // 4: over-read, inputs change mid-read
    t = 16'($urandom); h = 16'($urandom);
    temp = t; hum = h;
    i2c_start();
    wr_byte(8'h89, a); chk("t4_raddr", a, 1);
    temp = 16'($urandom); hum = 16'($urandom);
    rd_xfer(8, 1'b0, t, h, "t4");
    i2c_stop();
    chk("t4_idle", st, 0);
    chk("t4_sda", sda_bus, 1);

    // 5: NACK after byte 2, then fresh START
    t = 16'($urandom); h = 16'($urandom);
    temp = t; hum = h;
    r0 = rd_cnt;
    i2c_start();
    wr_byte(8'h89, a); chk("t5_raddr", a, 1);
    rd_xfer(2, 1'b1, t, h, "t5");
    waitq();
    chk("t5_rel", sda_bus, 1);
    chk("t5_rd", rd_cnt - r0, 1);
    c0 = cv_cnt;
    i2c_start();
    wr_byte(8'h88, a); chk("t5_new_addr", a, 1);
    wr_byte(8'h5A, a); chk("t5_new_data", a, 1);
    i2c_stop();
    chk("t5_cv", cv_cnt - c0, 1);

    // 6: async reset while driving a 0 bit
    temp = 16'h0000; hum = 16'($urandom);
    i2c_start();
    wr_byte(8'h89, a); chk("t6_raddr", a, 1);
    waitq();
    chk("t6_drv", sda_bus, 0);
    chk("t6_read", st, 5);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_sda_rel", sda_bus, 1);
    chk("t6_state", st, 0);
    chk("t6_cmd", cmd_byte, 0);
    @(negedge clk) rst_n = 1'b1;
    i2c_stop();
    wb = 8'($urandom);
    i2c_start();
    wr_byte(8'h88, a); chk("t6_addr2", a, 1);
    wr_byte(wb, a); chk("t6_data2", a, 1);
    i2c_stop();
    chk("t6_cmd2", cmd_byte, wb);

    // Random transactions: optional-mismatch write, then Sr and a random-length read
    for (int it = 0; it < 6; it++) begin
      ad = ($urandom_range(0, 1) == 1) ? 7'h44 : 7'($urandom);
      wb = 8'($urandom);
      c0 = cv_cnt;
      i2c_start();
      wr_byte({ad, 1'b0}, a); chk($sformatf("r%0d_waddr", it), a, int'(ad == 7'h44));
      wr_byte(wb, a); chk($sformatf("r%0d_wdata", it), a, int'(ad == 7'h44));
      chk($sformatf("r%0d_cv", it), cv_cnt - c0, int'(ad == 7'h44));
      if (ad == 7'h44) chk($sformatf("r%0d_cmd", it), cmd_byte, wb);
      t = 16'($urandom); h = 16'($urandom);
      temp = t; hum = h;
      n = $urandom_range(1, 8);
      r0 = rd_cnt;
      i2c_start();
      wr_byte(8'h89, a); chk($sformatf("r%0d_raddr", it), a, 1);
      temp = 16'($urandom); hum = 16'($urandom);
      rd_xfer(n, 1'b1, t, h, $sformatf("r%0d", it));
      chk($sformatf("r%0d_rd", it), rd_cnt - r0, 1);
      i2c_stop();
      chk($sformatf("r%0d_idle", it), st, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
